// File: rtl/uart_rx.sv
// UART receiver: 8N1 frames on an idle-high line, mid-bit sampling, framing/overrun
// reporting, and a valid/ready handshake towards the core.
module uart_rx #(
    parameter int CLKS_PER_BIT = 6
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rx,
    input  logic       rx_ready,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       frame_error,
    output logic       overrun,
    output logic       busy
);

    localparam int HALF = (CLKS_PER_BIT - 1) / 2;
    localparam int CW   = $clog2(CLKS_PER_BIT);

    typedef enum logic [2:0] {IDLE, START, DATA, STOP, BREAK} state_t;

    state_t        state;
    logic [1:0]    sync;
    logic          rx_s;
    logic [CW-1:0] cnt;
    logic [2:0]    bit_idx;
    logic [7:0]    shreg;

    assign rx_s = sync[1];

    // Handshake: a byte transfers on any posedge where rx_valid and rx_ready are both high;
    // rx_data is held stable while rx_valid is high, and rx_ready means nothing otherwise.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= IDLE;
            sync        <= 2'b11;
            cnt         <= '0;
            bit_idx     <= 3'd0;
            shreg       <= 8'h00;
            rx_data     <= 8'h00;
            rx_valid    <= 1'b0;
            frame_error <= 1'b0;
            overrun     <= 1'b0;
            busy        <= 1'b0;
        end else begin
            sync        <= {sync[0], rx};
            frame_error <= 1'b0;

            // Consumption first; a delivery on the same edge below overrides rx_valid.
            if (rx_valid && rx_ready) begin
                rx_valid <= 1'b0;
                overrun  <= 1'b0;
            end

            case (state)
                IDLE: begin
                    if (!rx_s) begin
                        state <= START;
                        cnt   <= '0;
                        busy  <= 1'b1;
                    end
                end
                START: begin
                    if (cnt == CW'(HALF)) begin
                        cnt <= '0;
                        if (!rx_s) begin
                            state   <= DATA;
                            bit_idx <= 3'd0;
                        end else begin
                            state <= IDLE;
                            busy  <= 1'b0;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                DATA: begin
                    if (cnt == CW'(CLKS_PER_BIT - 1)) begin
                        cnt   <= '0;
                        shreg <= {rx_s, shreg[7:1]};
                        if (bit_idx == 3'd7) begin
                            state <= STOP;
                        end else begin
                            bit_idx <= bit_idx + 1'b1;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                STOP: begin
                    if (cnt == CW'(CLKS_PER_BIT - 1)) begin
                        cnt <= '0;
                        if (rx_s) begin
                            state <= IDLE;
                            busy  <= 1'b0;
                            if (!rx_valid || rx_ready) begin
                                rx_data  <= shreg;
                                rx_valid <= 1'b1;
                            end else begin
                                overrun <= 1'b1;
                            end
                        end else begin
                            frame_error <= 1'b1;
                            state       <= BREAK;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                BREAK: begin
                    // A held-low line is not a start bit; wait for it to go idle first.
                    if (rx_s) begin
                        state <= IDLE;
                        cnt   <= '0;
                        busy  <= 1'b0;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx: default 6-clock bit time plus a 16-clock instance.
module tb_uart_rx;

    logic       clk = 1'b0;
    logic       reset;
    logic       rx, rx_ready;
    logic [7:0] rx_data;
    logic       rx_valid, frame_error, overrun, busy;
    logic       rx_b, rx_ready_b;
    logic [7:0] rx_data_b;
    logic       rx_valid_b, frame_error_b, overrun_b, busy_b;

    always #5 clk = ~clk;

    uart_rx dut (
        .clk(clk), .reset(reset), .rx(rx), .rx_ready(rx_ready),
        .rx_data(rx_data), .rx_valid(rx_valid), .frame_error(frame_error),
        .overrun(overrun), .busy(busy)
    );

    uart_rx #(.CLKS_PER_BIT(16)) dut_b (
        .clk(clk), .reset(reset), .rx(rx_b), .rx_ready(rx_ready_b),
        .rx_data(rx_data_b), .rx_valid(rx_valid_b), .frame_error(frame_error_b),
        .overrun(overrun_b), .busy(busy_b)
    );

    int total = 0;
    int bad   = 0;
    logic [7:0] got_q[$];
    logic [7:0] got_b_q[$];
    int fe_cnt    = 0;
    int fe_b_cnt  = 0;
    int valid_cyc = 0;

    // Record every accepted byte and every error/valid cycle, away from the active edge.
    always @(negedge clk) begin
        if (rx_valid && rx_ready) got_q.push_back(rx_data);
        if (frame_error) fe_cnt++;
        if (rx_valid) valid_cyc++;
        if (rx_valid_b && rx_ready_b) got_b_q.push_back(rx_data_b);
        if (frame_error_b) fe_b_cnt++;
    end

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic ticks(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_bit(input logic b, input int n, input bit big);
        if (big) rx_b = b;
        else     rx   = b;
        ticks(n);
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stop, input bit big);
        int cpb;
        cpb = big ? 16 : 6;
        send_bit(1'b0, cpb, big);
        for (int i = 0; i < 8; i++) send_bit(d[i], cpb, big);
        send_bit(stop, cpb, big);
    endtask

    function automatic logic [7:0] last_got();
        return (got_q.size() > 0) ? got_q[got_q.size()-1] : 8'hxx;
    endfunction

    initial begin
        logic [7:0] d66;
        logic [7:0] dc3;
        d66 = 8'h66;
        dc3 = 8'hC3;

        // Reset state
        reset = 1'b0; rx = 1'b1; rx_b = 1'b1; rx_ready = 1'b0; rx_ready_b = 1'b0;
        ticks(3);
        @(negedge clk);
        check("rst_data",   16'(rx_data), 16'h00);
        check("rst_valid",  16'(rx_valid), 16'h0);
        check("rst_fe",     16'(frame_error), 16'h0);
        check("rst_ovr",    16'(overrun), 16'h0);
        check("rst_busy",   16'(busy), 16'h0);
        check("rst_b_busy", 16'(busy_b), 16'h0);
        ticks(1);
        reset = 1'b1;
        ticks(4);

        // Good frame 0xA5, then 0x00 and 0xFF back-to-back
        rx_ready = 1'b1;
        send_frame(8'hA5, 1'b1, 1'b0);
        ticks(4);
        @(negedge clk);
        check("a5_count", 16'(got_q.size()), 16'd1);
        check("a5_data",  16'(last_got()), 16'hA5);
        check("a5_pulse", 16'(valid_cyc), 16'd1);
        check("a5_fe",    16'(fe_cnt), 16'd0);
        check("a5_busy",  16'(busy), 16'h0);
        ticks(1);
        send_frame(8'h00, 1'b1, 1'b0);
        send_frame(8'hFF, 1'b1, 1'b0);
        ticks(4);
        @(negedge clk);
        check("b2b_count", 16'(got_q.size()), 16'd3);
        check("b2b_first", 16'(got_q[1]), 16'h00);
        check("b2b_second", 16'(got_q[2]), 16'hFF);
        check("b2b_pulses", 16'(valid_cyc), 16'd3);
        ticks(1);

        // Glitch: two low clocks, then high
        send_bit(1'b0, 2, 1'b0);
        send_bit(1'b1, 2, 1'b0);
        @(negedge clk);
        check("glitch_busy_hi", 16'(busy), 16'h1);
        ticks(10);
        @(negedge clk);
        check("glitch_busy_lo", 16'(busy), 16'h0);
        check("glitch_valid",   16'(rx_valid), 16'h0);
        check("glitch_count",   16'(got_q.size()), 16'd3);
        check("glitch_fe",      16'(fe_cnt), 16'd0);
        ticks(1);

        // Framing error on 0x3C, line held low, then recovery with 0x11
        send_frame(8'h3C, 1'b0, 1'b0);
        send_bit(1'b0, 30, 1'b0);
        @(negedge clk);
        check("brk_fe_once", 16'(fe_cnt), 16'd1);
        check("brk_busy",    16'(busy), 16'h1);
        check("brk_valid",   16'(rx_valid), 16'h0);
        check("brk_count",   16'(got_q.size()), 16'd3);
        ticks(1);
        rx = 1'b1;
        ticks(6);
        @(negedge clk);
        check("brk_idle_busy", 16'(busy), 16'h0);
        check("brk_fe_final",  16'(fe_cnt), 16'd1);
        ticks(1);
        send_frame(8'h11, 1'b1, 1'b0);
        ticks(4);
        @(negedge clk);
        check("rec_count", 16'(got_q.size()), 16'd4);
        check("rec_data",  16'(last_got()), 16'h11);
        ticks(1);

        // Overrun: 0x12 pending, 0x34 dropped
        rx_ready = 1'b0;
        send_frame(8'h12, 1'b1, 1'b0);
        send_frame(8'h34, 1'b1, 1'b0);
        ticks(4);
        @(negedge clk);
        check("ovr_valid", 16'(rx_valid), 16'h1);
        check("ovr_data",  16'(rx_data), 16'h12);
        check("ovr_flag",  16'(overrun), 16'h1);
        ticks(1);
        rx_ready = 1'b1;
        ticks(1);
        rx_ready = 1'b0;
        @(negedge clk);
        check("ovr_clr_valid", 16'(rx_valid), 16'h0);
        check("ovr_clr_flag",  16'(overrun), 16'h0);
        check("ovr_consumed",  16'(last_got()), 16'h12);
        check("ovr_count",     16'(got_q.size()), 16'd5);
        ticks(1);

        // Consume 0x55 exactly on the stop-sample edge of 0x66
        send_frame(8'h55, 1'b1, 1'b0);
        ticks(4);
        @(negedge clk);
        check("sim_pending", 16'(rx_data), 16'h55);
        ticks(1);
        send_bit(1'b0, 6, 1'b0);
        for (int i = 0; i < 8; i++) send_bit(d66[i], 6, 1'b0);
        rx = 1'b1;
        ticks(5);
        rx_ready = 1'b1;
        ticks(1);
        rx_ready = 1'b0;
        @(negedge clk);
        check("sim_valid",    16'(rx_valid), 16'h1);
        check("sim_data",     16'(rx_data), 16'h66);
        check("sim_ovr",      16'(overrun), 16'h0);
        check("sim_consumed", 16'(last_got()), 16'h55);
        ticks(1);
        rx_ready = 1'b1;
        ticks(1);
        rx_ready = 1'b0;
        @(negedge clk);
        check("sim_drain_valid", 16'(rx_valid), 16'h0);
        check("sim_drain_data",  16'(last_got()), 16'h66);
        ticks(1);

        // Reset during data bit 4 of 0xC3
        rx_ready = 1'b1;
        send_bit(1'b0, 6, 1'b0);
        for (int i = 0; i < 4; i++) send_bit(dc3[i], 6, 1'b0);
        send_bit(dc3[4], 3, 1'b0);
        @(negedge clk);
        check("mid_busy", 16'(busy), 16'h1);
        reset = 1'b0;
        #1;
        check("mid_rst_busy",  16'(busy), 16'h0);
        check("mid_rst_data",  16'(rx_data), 16'h00);
        check("mid_rst_valid", 16'(rx_valid), 16'h0);
        send_bit(dc3[4], 3, 1'b0);
        for (int i = 5; i < 8; i++) send_bit(dc3[i], 6, 1'b0);
        send_bit(1'b1, 6, 1'b0);
        ticks(4);
        reset = 1'b1;
        ticks(8);
        @(negedge clk);
        check("post_rst_busy",  16'(busy), 16'h0);
        check("post_rst_valid", 16'(rx_valid), 16'h0);
        check("post_rst_count", 16'(got_q.size()), 16'd7);
        ticks(1);

        // 16-clock bit time
        rx_ready_b = 1'b1;
        send_frame(8'hC3, 1'b1, 1'b1);
        ticks(4);
        @(negedge clk);
        check("p16_count", 16'(got_b_q.size()), 16'd1);
        check("p16_data",  16'((got_b_q.size() > 0) ? got_b_q[0] : 8'hxx), 16'hC3);
        check("p16_fe",    16'(fe_b_cnt), 16'd0);
        check("p16_busy",  16'(busy_b), 16'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
